muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multi-cycle RV32M multiply/divide unit. It is the responder side of a valid/ready request/response pair driven by the execute stage. It offloads all eight M-extension operations from the single-cycle ALU, trading latency for area. It completes one operation at a time, one radix-2 step per clock.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 6, iteration counter width (holds 0..XLEN)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_a  in  32  rs1 operand
req_b  in  32  rs2 operand
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_result  out  32  result
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk). Asynchronous active-high reset (rst) forces state IDLE, counter 0, resp_valid 0, resp_result 0, and all internal operand/accumulator registers 0.
- req_ready = (state == IDLE) && !rst.
- States:
  - IDLE -> CALC on accept.
  - IDLE -> DONE on accept when the operation is a fast-path case.
  - CALC -> DONE when the counter reaches 32.
  - DONE -> IDLE when resp_ready is sampled high.
- Accept: req_valid && req_ready at a rising edge. req_op, req_a and req_b are captured at that edge. Later changes on the req_* inputs are ignored until the next accept.
- Signed handling: operands are converted to magnitudes at accept, then an unsigned core runs.
  - MUL, MULH: both operands are signed.
  - MULHSU: a is signed, b is unsigned.
  - MULHU: both unsigned.
  - DIV, REM: both signed.
  - DIVU, REMU: both unsigned.
- Result sign fix-up happens on the CALC -> DONE transition:
  - Product negated if sign(a) xor sign(b), using only the signed operands.
  - Quotient negated if sign(a) xor sign(b).
  - Remainder takes sign(a).
- Multiply: shift-add over a 64-bit accumulator, one multiplier bit per CALC cycle.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32] of the sign-corrected 64-bit product.
- Divide: restoring, one quotient bit per CALC cycle, MSB first.
  - DIV/DIVU return the quotient.
  - REM/REMU return the remainder.
- Fast path: resp_valid goes high in the cycle after accept; CALC is skipped.
  - DIV/DIVU with b==0: result 0xFFFFFFFF.
  - REM/REMU with b==0: result a.
  - DIV with a==0x80000000, b==0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- Latency: accept at edge N.
  - Normal operations occupy CALC for 32 edges (N+1..N+32). resp_valid is high from edge N+32.
  - Fast path: resp_valid is high from edge N.
- Response:
  - resp_valid and resp_result are registered and stable while in DONE until the handshake (resp_valid && resp_ready at an edge). After that edge, resp_valid = 0.
  - resp_result holds its last value afterwards.
  - resp_ready is ignored outside DONE.
- No request is accepted in the cycle a response is consumed. A new accept requires IDLE, so the minimum spacing is 1 idle cycle.
- Reset mid-operation (CALC or DONE): the operation is aborted with no response. The unit is in IDLE with req_ready high after rst deasserts.
- busy is high in CALC and DONE.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB after exactly 32 cycles. MULH with a=b=0x80000000 -> 0x40000000.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU with the same operands -> 2.
- Fast path, each with resp_valid high one cycle after accept:
  - DIVU a=5, b=0 -> 0xFFFFFFFF.
  - REM a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_result stable, req_ready=0. Assert resp_ready -> IDLE next cycle. Change req_a mid-CALC -> result unaffected.
- Assert rst asynchronously at CALC cycle 15 -> resp_valid=0 and resp_result=0 immediately, no response emitted. After release, req_ready=1 and a new MUL 3*4 returns 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one step per clock, with a valid/ready request/response handshake.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);
    localparam int unsigned AW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand decode at accept: signedness, magnitudes, result sign and fast-path detection
    logic            sgn_a, sgn_b, neg_a, neg_b, neg_res;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;
    logic            div_zero, div_ovf, fast;

    assign sgn_a    = req_op[2] ? ~req_op[0] : (req_op[1:0] != 2'b11);
    assign sgn_b    = req_op[2] ? ~req_op[0] : ~req_op[1];
    assign neg_a    = sgn_a & req_a[XLEN-1];
    assign neg_b    = sgn_b & req_b[XLEN-1];
    assign mag_a    = neg_a ? -req_a : req_a;
    assign mag_b    = neg_b ? -req_b : req_b;
    assign neg_res  = (req_op[2] && req_op[1]) ? neg_a : (neg_a ^ neg_b);
    assign div_zero = req_op[2] && (req_b == '0);
    assign div_ovf  = req_op[2] && !req_op[0] && (req_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (req_b == '1);
    assign fast     = div_zero || div_ovf;
    assign fast_res = div_zero ? (req_op[1] ? req_a : '1) : (req_op[1] ? '0 : req_a);

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [XLEN:0]   mul_sum, div_rem;
    logic [XLEN-1:0] div_diff, new_rem;
    logic            qbit;
    logic [AW-1:0]   step_next, mul_full;
    logic [XLEN-1:0] div_sel, fin_res;

    assign mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign div_rem   = acc_q[AW-1:XLEN-1];
    assign qbit      = (div_rem >= {1'b0, opd_q});
    assign div_diff  = XLEN'(div_rem - {1'b0, opd_q});
    assign new_rem   = qbit ? div_diff : div_rem[XLEN-1:0];
    assign step_next = op_q[2] ? {new_rem, acc_q[XLEN-2:0], qbit}
                               : {mul_sum, acc_q[XLEN-1:1]};

    // Sign fix-up applied to the value produced by the final iteration
    assign mul_full  = neg_q ? -step_next : step_next;
    assign div_sel   = op_q[1] ? step_next[AW-1:XLEN] : step_next[XLEN-1:0];
    assign fin_res   = op_q[2] ? (neg_q ? -div_sel : div_sel)
                               : ((op_q[1:0] == 2'b00) ? mul_full[XLEN-1:0]
                                                       : mul_full[AW-1:XLEN]);

    assign req_ready   = (state_q == IDLE) && !rst;
    assign busy        = (state_q != IDLE);
    assign resp_valid  = valid_q;
    assign resp_result = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        valid_d  = valid_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_d  = req_op;
                    neg_d = neg_res;
                    cnt_d = '0;
                    if (fast) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = fast_res;
                    end else begin
                        state_d = CALC;
                        opd_d   = req_op[2] ? mag_b : mag_a;
                        acc_d   = {{XLEN{1'b0}}, (req_op[2] ? mag_a : mag_b)};
                    end
                end
            end
            CALC: begin
                acc_d = step_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = fin_res;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes hand-computed expectations,
// a monitor pops and checks result, latency, and hold-off behaviour.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        busy;

    muldiv_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
        int          hold;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   next_id = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (op #%0d): got %h, expected %h", name, id, act, exp);
    endtask

    // Present one request, wait for acceptance, optionally queue its expectation
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int hold,
                         input bit scramble, input bit push);
        int   w;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        w = 0;
        while (!req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("accept_timeout", next_id, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.res = exp; e.acc_cyc = cyc; e.lat = lat; e.hold = hold; e.id = next_id;
        if (push) q.push_back(e);
        next_id++;
        req_valid = 1'b0;
        if (scramble) begin
            repeat (5) @(negedge clk);
            req_a = ~req_a; req_b = 32'h0000_1234; req_op = 3'b000;
        end
    endtask

    // Monitor: pop on each new response, check it, apply hold-off, then consume
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_response", -1, resp_result, 32'hxxxx_xxxx);
                    resp_ready = 1'b1;
                    @(negedge clk);
                    resp_ready = 1'b0;
                end else begin
                    e = q.pop_front();
                    chk("latency", e.id, 32'(cyc - e.acc_cyc), 32'(e.lat));
                    for (int k = 0; k < e.hold; k++) begin
                        chk("hold_result", e.id, resp_result, e.res);
                        chk("hold_valid", e.id, 32'(resp_valid), 32'd1);
                        chk("hold_req_ready", e.id, 32'(req_ready), 32'd0);
                        @(negedge clk);
                    end
                    chk("result", e.id, resp_result, e.res);
                    chk("busy_done", e.id, 32'(busy), 32'd1);
                    resp_ready = 1'b1;
                    @(negedge clk);
                    resp_ready = 1'b0;
                    chk("post_valid", e.id, 32'(resp_valid), 32'd0);
                    chk("post_idle", e.id, 32'(req_ready), 32'd1);
                end
            end
        end
    end

    initial begin : main
        int w;
        #3;
        chk("rst_resp_valid", -1, 32'(resp_valid), 32'd0);
        chk("rst_resp_result", -1, resp_result, 32'd0);
        chk("rst_busy", -1, 32'(busy), 32'd0);
        chk("rst_req_ready", -1, 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", -1, 32'(req_ready), 32'd1);

        issue(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 0, 0, 1); // MUL
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, 0, 0, 1); // MULH
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 0, 0, 1); // MULHU
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 0, 0, 1); // MULHSU
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32, 0, 0, 1); // DIV
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32, 0, 0, 1); // REM
        issue(3'b101, 32'd100,       32'd7,         32'd14,        32, 0, 1, 1); // DIVU, inputs disturbed mid-op
        issue(3'b111, 32'd100,       32'd7,         32'd2,         32, 0, 0, 1); // REMU
        issue(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF,  0, 0, 0, 1); // DIVU /0
        issue(3'b110, 32'd5,         32'd0,         32'd5,          0, 0, 0, 1); // REM /0
        issue(3'b111, 32'd9,         32'd0,         32'd9,          0, 0, 0, 1); // REMU /0
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  0, 0, 0, 1); // DIV overflow
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          0, 0, 0, 1); // REM overflow
        issue(3'b011, 32'h1234_5678, 32'h0000_0010, 32'd1,         32, 10, 0, 1); // MULHU, backpressure

        // Abort a multiply with an asynchronous reset partway through CALC
        issue(3'b000, 32'h0000_1111, 32'h0000_2222, 32'd0, 0, 0, 0, 0);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_resp_valid", -1, 32'(resp_valid), 32'd0);
        chk("abort_resp_result", -1, resp_result, 32'd0);
        chk("abort_busy", -1, 32'(busy), 32'd0);
        chk("abort_req_ready", -1, 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_release_ready", -1, 32'(req_ready), 32'd1);
        issue(3'b000, 32'd3, 32'd4, 32'd12, 32, 0, 0, 1);

        w = 0;
        while ((q.size() != 0 || resp_valid || resp_ready) && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("drain_queue", -1, 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
